// File: rtl/pwm_audio_out.sv
// pwm_audio_out: double-buffered PWM audio output stage.
//
// Takes WIDTH-bit unsigned samples over a valid/ready handshake into a
// holding register. The holding register is copied into the duty register
// only at frame boundaries, so the duty cycle of a frame never changes while
// it plays. Each frame lasts 2^WIDTH counts of PRESCALE clocks.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   enable         playback enable; dropping it finishes the current frame
//   s_data/s_valid sample input; s_ready = holding register empty
//   pwm_out        registered PWM bit (lags the counters by one clock)
//   frame_start    one-cycle pulse on the first pwm_out cycle of a frame
//   underrun       one-cycle pulse, aligned with frame_start, when the frame
//                  started without a fresh sample
//   underrun_count saturating count of underruns
//   active         high while in RUN
module pwm_audio_out #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE   = 1,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  pwm_out,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [UNDERRUN_W-1:0] underrun_count,
  output logic                  active
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  // Boundary decisions are taken on the last counter cycle of a frame but
  // become visible one clock later, together with the first pwm_out cycle of
  // the new frame. These flags carry the decision across that clock.
  logic                  load_pend_q, load_pend_d;
  logic                  urun_pend_q, urun_pend_d;
  logic                  pwm_q, pwm_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic [UNDERRUN_W-1:0] ucount_q, ucount_d;

  logic tick_end, frame_end, xfer, first_cnt;

  assign tick_end  = (presc_q == PW'(PRESCALE - 1));
  assign frame_end = tick_end && (cnt_q == {WIDTH{1'b1}});
  assign first_cnt = (cnt_q == '0) && (presc_q == '0);
  assign s_ready   = !rst && !hold_full_q;
  assign xfer      = s_valid && s_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (!enable) state_d = IDLE;
               else if (hold_full_q) state_d = RUN;
      RUN:     if (frame_end && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    active = (state_q == RUN);
  end

  // Datapath
  always_comb begin
    presc_d       = presc_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    load_pend_d   = load_pend_q;
    urun_pend_d   = urun_pend_q;
    ucount_d      = ucount_q;
    pwm_d         = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (xfer) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
      end
      PRIME: begin
        presc_d = '0;
        cnt_d   = '0;
        if (enable && hold_full_q) begin
          duty_d      = hold_q;
          load_pend_d = 1'b1;
        end
      end
      RUN: begin
        pwm_d         = (cnt_q < duty_q);
        frame_start_d = first_cnt;
        if (tick_end) begin
          presc_d = '0;
          cnt_d   = cnt_q + WIDTH'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // First counter cycle of a frame: release the holding register the
        // frame's duty came from (s_ready rises with frame_start) and publish
        // any underrun decided at the previous boundary.
        if (first_cnt) begin
          if (load_pend_q) hold_full_d = 1'b0;
          load_pend_d = 1'b0;
          underrun_d  = urun_pend_q;
          if (urun_pend_q && (ucount_q != {UNDERRUN_W{1'b1}}))
            ucount_d = ucount_q + UNDERRUN_W'(1);
          urun_pend_d = 1'b0;
        end
        // Frame boundary with playback continuing. A transfer landing in this
        // same cycle fills hold but cannot rescue this boundary.
        if (frame_end && enable) begin
          if (hold_full_q) begin
            duty_d      = hold_q;
            load_pend_d = 1'b1;
          end else begin
            urun_pend_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      cnt_q         <= '0;
      duty_q        <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      load_pend_q   <= 1'b0;
      urun_pend_q   <= 1'b0;
      ucount_q      <= '0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      load_pend_q   <= load_pend_d;
      urun_pend_q   <= urun_pend_d;
      ucount_q      <= ucount_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       rst, enable, s_valid;
  logic [7:0] s_data;

  logic       s_ready1, pwm1, fs1, ur1, act1;
  logic [1:0] uc1;
  logic       s_ready3, pwm3, fs3, ur3, act3;
  logic [7:0] uc3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(.WIDTH(8), .PRESCALE(1), .UNDERRUN_W(2)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready1), .pwm_out(pwm1), .frame_start(fs1), .underrun(ur1),
    .underrun_count(uc1), .active(act1));

  pwm_audio_out #(.WIDTH(8), .PRESCALE(3), .UNDERRUN_W(8)) u3 (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready3), .pwm_out(pwm3), .frame_start(fs3), .underrun(ur3),
    .underrun_count(uc3), .active(act3));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input int sel, input int max, output int ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if ((sel == 0 && fs1) || (sel == 1 && fs3)) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  // Samples the current cycle first, then advances; returns n cycles later.
  task automatic measure(input int sel, input int n,
                         output int hi, output int fs, output int ur,
                         output int first_low);
    hi = 0; fs = 0; ur = 0; first_low = -1;
    for (int i = 0; i < n; i++) begin
      if ((sel == 0) ? pwm1 : pwm3) hi++;
      else if (first_low < 0) first_low = i;
      if ((sel == 0) ? fs1 : fs3) fs++;
      if ((sel == 0) ? ur1 : ur3) ur++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, fs, ur, fl, ok, xfers, xfer_now;
    int exp_uc[4] = '{1, 2, 3, 3};

    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0;
    step(); step();
    // Reset state
    chk("rst_pwm", pwm1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_ur", ur1, 0);
    chk("rst_act", act1, 0);
    chk("rst_uc", uc1, 0);
    chk("rst_ready", s_ready1, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_ready1, 1);

    // Prime 64 while IDLE, then play 64 continuously
    s_valid = 1'b1; s_data = 8'd64;
    step();
    s_valid = 1'b0;
    chk("prime_ready", s_ready1, 0);
    chk("prime_idle_act", act1, 0);
    enable = 1'b1; s_valid = 1'b1;
    wait_fs(0, 20, ok);
    chk("first_fs_seen", ok, 1);
    chk("run_act", act1, 1);
    measure(0, 256, hi, fs, ur, fl);
    chk("d64_hi", hi, 64);
    chk("d64_first_low", fl, 64);
    chk("d64_fs", fs, 1);
    chk("d64_ur", ur, 0);
    chk("d64_next_fs", fs1, 1);

    // Duty 0 then 255
    s_data = 8'd0;
    step();
    s_data = 8'd255;
    measure(0, 255, hi, fs, ur, fl);
    chk("d0_fs_at", fs1, 1);
    measure(0, 256, hi, fs, ur, fl);
    chk("d0_hi", hi, 0);
    chk("d0_fs", fs, 1);
    measure(0, 256, hi, fs, ur, fl);
    chk("d255_hi", hi, 255);
    chk("d255_first_low", fl, 255);

    // Single sample 100, then starve
    s_data = 8'd100;
    step();
    s_valid = 1'b0;
    measure(0, 255, hi, fs, ur, fl);
    chk("u_fs_at", fs1, 1);
    chk("u_no_ur_yet", ur1, 0);
    measure(0, 256, hi, fs, ur, fl);
    chk("u_first_hi", hi, 100);
    chk("u_first_ur", ur, 0);
    for (int k = 0; k < 4; k++) begin
      chk("u_pulse", ur1, 1);
      chk("u_fs", fs1, 1);
      chk("u_count", uc1, exp_uc[k]);
      measure(0, 256, hi, fs, ur, fl);
      chk("u_repeat_hi", hi, 100);
      chk("u_ur_per_frame", ur, 1);
    end

    // Put 77 in hold, then drop enable at cnt=10
    s_valid = 1'b1; s_data = 8'd77;
    step();
    s_valid = 1'b0;
    chk("hold_ready", s_ready1, 0);
    repeat (9) step();
    enable = 1'b0;
    measure(0, 246, hi, fs, ur, fl);
    chk("en_tail_hi", hi, 90);
    chk("en_tail_fs", fs, 0);
    chk("en_off_fs", fs1, 0);
    chk("en_off_act", act1, 0);
    chk("en_off_pwm", pwm1, 0);
    chk("en_off_ready", s_ready1, 0);
    measure(0, 300, hi, fs, ur, fl);
    chk("idle_hi", hi, 0);
    chk("idle_fs", fs, 0);
    chk("idle_ur", ur, 0);
    chk("idle_uc", uc1, 3);

    // Resume on retained 77, reset at cnt=100
    enable = 1'b1;
    wait_fs(0, 20, ok);
    chk("resume_fs_seen", ok, 1);
    measure(0, 100, hi, fs, ur, fl);
    chk("resume_hi", hi, 77);
    rst = 1'b1;
    step();
    chk("mid_rst_pwm", pwm1, 0);
    chk("mid_rst_fs", fs1, 0);
    chk("mid_rst_ur", ur1, 0);
    chk("mid_rst_act", act1, 0);
    chk("mid_rst_uc", uc1, 0);
    chk("mid_rst_ready", s_ready1, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", s_ready1, 1);

    // Streaming 1, 2, 3, ... with s_valid held high
    s_valid = 1'b1; s_data = 8'd1;
    step();
    s_data = 8'd2;
    chk("stream_prime_ready", s_ready1, 0);
    wait_fs(0, 20, ok);
    chk("stream_fs_seen", ok, 1);
    for (int f = 1; f <= 3; f++) begin
      chk("stream_fs", fs1, 1);
      chk("stream_ready_at_fs", s_ready1, 1);
      hi = 0; xfers = 0;
      for (int i = 0; i < 256; i++) begin
        xfer_now = s_ready1 ? 1 : 0;
        if (pwm1) hi++;
        step();
        if (xfer_now != 0) begin
          xfers++;
          s_data = s_data + 8'd1;
          chk("stream_ready_drop", s_ready1, 0);
        end
      end
      chk("stream_hi", hi, f);
      chk("stream_xfers", xfers, 1);
    end

    // PRESCALE=3 instance
    s_valid = 1'b0; enable = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    s_valid = 1'b1; s_data = 8'd64;
    step();
    s_valid = 1'b0; enable = 1'b1;
    wait_fs(1, 20, ok);
    chk("p3_fs_seen", ok, 1);
    measure(1, 768, hi, fs, ur, fl);
    chk("p3_hi", hi, 192);
    chk("p3_first_low", fl, 192);
    chk("p3_fs", fs, 1);
    chk("p3_next_fs", fs3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
